imem_stream_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the instruction memory.
- Accepts a byte stream from a host link (UART receiver / testbench) carrying a word-count header plus program words.
- Assembles big-endian 32-bit instructions and writes them word by word into instruction memory.
- Holds the processor off (cpu_run low) until the full image is written, then releases it with PC starting at 0.

---
 rtl/imem_stream_loader_if.sv | 20 ++
 rtl/imem_stream_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_stream_loader.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_stream_loader_if.sv
// Byte-stream handshake between the host link and the program loader.
interface imem_stream_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Host side: presents bytes, observes back-pressure.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Loader side: consumes bytes, drives back-pressure.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot-time loader: takes a 16-bit word-count header followed by big-endian
// 32-bit words from a byte stream, writes them into instruction memory, and
// releases the CPU once the full image is in place.
module imem_stream_loader #(
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_stream_loader_if.slave stream,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_run,
    output logic                done,
    output logic                error,
    output logic [CNT_W-1:0]    words_loaded
);

    localparam int unsigned     ADDR_W  = 32;
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX_N  = CNT_W'(MAX_WORDS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    state_t           state_d;

    logic             ready_q;
    logic             ready_d;
    logic             run_d;
    logic             err_d;
    logic             xfer;
    logic             timer_active;
    logic             timeout_hit;
    logic             hdr_bad;
    logic             last_word;

    logic [7:0]       hdr_hi;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] n_full;
    logic [23:0]      shift;
    logic [1:0]       byte_idx;
    logic [TO_W-1:0]  to_cnt;

    assign stream.in_ready = ready_q;

    // Next-state decode plus the registered status flags derived from it.
    always_comb begin
        state_d      = state;
        ready_d      = 1'b0;
        run_d        = 1'b0;
        err_d        = 1'b0;
        xfer         = stream.in_valid && ready_q;
        timer_active = (state == S_HDR_LO) || (state == S_LOAD);
        timeout_hit  = timer_active && !xfer && (to_cnt == TO_LAST);
        n_full       = CNT_W'({hdr_hi, stream.in_data});
        hdr_bad      = (n_full == '0) || (n_full > MAX_N);
        last_word    = (words_loaded + CNT_W'(1)) == n_words;

        case (state)
            S_HDR_HI: begin
                if (xfer) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (xfer)             state_d = hdr_bad ? S_ERROR : S_LOAD;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_LOAD: begin
                if (xfer && (byte_idx == 2'd3)) state_d = S_WRITE;
                else if (timeout_hit)           state_d = S_ERROR;
            end
            S_WRITE: begin
                state_d = last_word ? S_DONE : S_LOAD;
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_LOAD);
        run_d   = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_HDR_HI;
        else        state <= state_d;
    end

    // Datapath: header capture, word assembly, memory write port, timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q      <= 1'b1;
            cpu_run      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            hdr_hi       <= '0;
            n_words      <= '0;
            shift        <= '0;
            byte_idx     <= '0;
            to_cnt       <= '0;
        end else begin
            ready_q <= ready_d;
            cpu_run <= run_d;
            done    <= run_d;
            error   <= err_d;
            imem_we <= 1'b0;

            // Idle-gap timer restarts on every byte and on each state entry.
            if (xfer || (state_d != state)) begin
                to_cnt <= '0;
            end else if (timer_active) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            case (state)
                S_HDR_HI: begin
                    if (xfer) hdr_hi <= stream.in_data;
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        n_words      <= n_full;
                        byte_idx     <= '0;
                        words_loaded <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        shift    <= {shift[15:0], stream.in_data};
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte completes the word; present it for one cycle.
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_W'({words_loaded, 2'b00});
                            imem_wdata <= {shift, stream.in_data};
                        end
                    end
                end
                S_WRITE: begin
                    if (words_loaded != n_words) words_loaded <= words_loaded + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized self-checking bench for imem_stream_loader: a default-sized
// instance and a 4-word instance share one host driver selected by 'sel'.
module tb_imem_stream_loader;

    localparam int unsigned TO    = 1000;
    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        h_valid;
    logic [7:0]  h_data;

    imem_stream_loader_if sa();
    imem_stream_loader_if sb();

    logic             a_we, b_we, a_run, b_run, a_done, b_done, a_err, b_err;
    logic [31:0]      a_addr, b_addr, a_wdata, b_wdata;
    logic [CNT_W-1:0] a_words, b_words;

    logic             h_ready, m_we, m_run, m_done, m_err;
    logic [31:0]      m_addr, m_wdata;
    logic [CNT_W-1:0] m_words;

    assign sa.in_valid = h_valid & ~sel;
    assign sa.in_data  = h_data;
    assign sb.in_valid = h_valid & sel;
    assign sb.in_data  = h_data;

    assign h_ready = sel ? sb.in_ready : sa.in_ready;
    assign m_we    = sel ? b_we    : a_we;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_wdata = sel ? b_wdata : a_wdata;
    assign m_run   = sel ? b_run   : a_run;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_words = sel ? b_words : a_words;

    imem_stream_loader #(.MAX_WORDS(1024), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .stream(sa),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .cpu_run(a_run), .done(a_done), .error(a_err), .words_loaded(a_words)
    );

    imem_stream_loader #(.MAX_WORDS(4), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .stream(sb),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_run(b_run), .done(b_done), .error(b_err), .words_loaded(b_words)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor, sampled on the falling edge between active edges.
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          stall_bad = 0;
    int          we_ready_bad = 0;
    int          run_rise_cyc = -1;
    logic        prev_run = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (h_valid && h_ready) acc_cnt = acc_cnt + 1;
        if (m_we) begin
            q_addr.push_back(m_addr);
            q_data.push_back(m_wdata);
            q_cyc.push_back(cyc);
            if (h_ready) we_ready_bad = we_ready_bad + 1;
        end
        if (rst_n && h_valid && !h_ready && !m_we && !m_err && !m_done)
            stall_bad = stall_bad + 1;
        if (m_run && !prev_run) run_rise_cyc = cyc;
        prev_run = m_run;
    end

    // Reference: what a correct loader writes for a given byte image.
    task automatic model(input logic [7:0] b[$], input int maxw,
                         output logic [31:0] ea[$], output logic [31:0] ed[$],
                         output bit eerr);
        int n;
        ea.delete();
        ed.delete();
        n    = int'(b[0]) * 256 + int'(b[1]);
        eerr = (n == 0) || (n > maxw);
        if (!eerr) begin
            for (int i = 0; i < n; i++) begin
                ea.push_back(32'(4 * i));
                ed.push_back({b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
            end
        end
    endtask

    task automatic do_reset();
        h_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        h_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer each byte until taken, with an optional random idle gap before it.
    task automatic send(input logic [7:0] b[$], input int max_gap, output bit ok);
        ok = 1'b1;
        foreach (b[k]) begin
            bit got;
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (g > 0) idle(g);
            h_valid = 1'b1;
            h_data  = b[k];
            got     = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                if (h_ready) got = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!got) begin
                ok = 1'b0;
                break;
            end
        end
        h_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int w = 0; w < 40 && !m_done && !m_err; w++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        total++; if (h_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", h_ready); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", m_we); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", m_addr); end
        total++; if (m_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", m_wdata); end
        total++; if (m_run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b exp=0", m_run); end
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", m_done); end
        total++; if (m_err !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", m_err); end
        total++; if (m_words !== '0) begin bad++; $display("FAIL reset_words got=%0d exp=0", m_words); end
    endtask

    task automatic test_basic();
        logic [7:0]  b[$];
        logic [31:0] ea[$], ed[$];
        bit          eerr, ok;
        int          base, a0;
        sel = 1'b0;
        do_reset();
        b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        model(b, 1024, ea, ed, eerr);
        base = q_addr.size();
        a0   = acc_cnt;
        send(b, 0, ok);
        // Keep offering junk: nothing beyond the image may be taken.
        h_valid = 1'b1;
        repeat (8) begin
            h_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        h_valid = 1'b0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_send got=%b exp=1", ok); end
        total++; if (q_addr.size() - base !== 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", q_addr.size() - base); end
        for (int i = 0; i < ea.size() && base + i < q_addr.size(); i++) begin
            total++; if (q_addr[base+i] !== ea[i]) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, q_addr[base+i], ea[i]); end
            total++; if (q_data[base+i] !== ed[i]) begin bad++; $display("FAIL basic_data%0d got=%h exp=%h", i, q_data[base+i], ed[i]); end
        end
        total++; if (acc_cnt - a0 !== 10) begin bad++; $display("FAIL basic_accepted got=%0d exp=10", acc_cnt - a0); end
        total++; if (m_run !== 1'b1) begin bad++; $display("FAIL basic_run got=%b exp=1", m_run); end
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", m_done); end
        total++; if (m_words !== 16'd2) begin bad++; $display("FAIL basic_words got=%0d exp=2", m_words); end
        total++; if (h_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_after got=%b exp=0", h_ready); end
        if (q_cyc.size() > base + 1) begin
            total++;
            if (run_rise_cyc - q_cyc[base+1] !== 1) begin
                bad++; $display("FAIL basic_run_latency got=%0d exp=1", run_rise_cyc - q_cyc[base+1]);
            end
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[3][2];
        logic [7:0] b[$];
        bit         ok;
        int         base, a0;
        hdrs[0] = '{8'h00, 8'h00};
        hdrs[1] = '{8'h04, 8'h01};
        hdrs[2] = '{8'h04, 8'h00};
        sel = 1'b0;
        for (int h = 0; h < 3; h++) begin
            do_reset();
            b    = '{hdrs[h][0], hdrs[h][1]};
            base = q_addr.size();
            send(b, 0, ok);
            idle(1);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL hdr%0d_send got=%b exp=1", h, ok); end
            if (h < 2) begin
                total++; if (m_err !== 1'b1) begin bad++; $display("FAIL hdr%0d_error got=%b exp=1", h, m_err); end
                total++; if (h_ready !== 1'b0) begin bad++; $display("FAIL hdr%0d_ready got=%b exp=0", h, h_ready); end
                total++; if (m_run !== 1'b0) begin bad++; $display("FAIL hdr%0d_run got=%b exp=0", h, m_run); end
                a0 = acc_cnt;
                h_valid = 1'b1;
                h_data  = 8'h5A;
                repeat (5) @(posedge clk);
                #1;
                h_valid = 1'b0;
                total++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL hdr%0d_refuse got=%0d exp=0", h, acc_cnt - a0); end
                total++; if (q_addr.size() - base !== 0) begin bad++; $display("FAIL hdr%0d_nowrite got=%0d exp=0", h, q_addr.size() - base); end
            end else begin
                // N equal to the memory depth is a legal image size.
                total++; if (m_err !== 1'b0) begin bad++; $display("FAIL hdr_max_error got=%b exp=0", m_err); end
                total++; if (h_ready !== 1'b1) begin bad++; $display("FAIL hdr_max_ready got=%b exp=1", h_ready); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b[$];
        bit         ok;
        int         base;
        sel = 1'b0;
        do_reset();
        b    = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        base = q_addr.size();
        send(b, 0, ok);
        idle(TO / 2);
        total++; if (m_err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", m_err); end
        idle(TO / 2 + 2);
        total++; if (m_err !== 1'b1) begin bad++; $display("FAIL timeout_error got=%b exp=1", m_err); end
        total++; if (m_run !== 1'b0) begin bad++; $display("FAIL timeout_run got=%b exp=0", m_run); end
        total++; if (q_addr.size() - base !== 0) begin bad++; $display("FAIL timeout_nowrite got=%0d exp=0", q_addr.size() - base); end
    endtask

    task automatic test_random_gaps();
        logic [7:0]  b[$];
        logic [31:0] ea[$], ed[$];
        bit          eerr, ok;
        int          base, s0, w0, n;
        sel = 1'b0;
        for (int it = 0; it < 5; it++) begin
            do_reset();
            n = (it == 0) ? 3 : int'($urandom_range(1, 6));
            b = '{8'(n >> 8), 8'(n)};
            for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
            model(b, 1024, ea, ed, eerr);
            base = q_addr.size();
            s0   = stall_bad;
            w0   = we_ready_bad;
            send(b, (it == 0) ? 20 : 6, ok);
            wait_end();
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd%0d_send got=%b exp=1", it, ok); end
            total++; if (q_addr.size() - base !== ea.size()) begin bad++; $display("FAIL rnd%0d_nwrites got=%0d exp=%0d", it, q_addr.size() - base, ea.size()); end
            for (int i = 0; i < ea.size() && base + i < q_addr.size(); i++) begin
                total++; if (q_addr[base+i] !== ea[i]) begin bad++; $display("FAIL rnd%0d_addr%0d got=%h exp=%h", it, i, q_addr[base+i], ea[i]); end
                total++; if (q_data[base+i] !== ed[i]) begin bad++; $display("FAIL rnd%0d_data%0d got=%h exp=%h", it, i, q_data[base+i], ed[i]); end
            end
            total++; if (we_ready_bad - w0 !== 0) begin bad++; $display("FAIL rnd%0d_ready_in_write got=%0d exp=0", it, we_ready_bad - w0); end
            total++; if (stall_bad - s0 !== 0) begin bad++; $display("FAIL rnd%0d_unexpected_stall got=%0d exp=0", it, stall_bad - s0); end
            total++; if (m_done !== 1'b1) begin bad++; $display("FAIL rnd%0d_done got=%b exp=1", it, m_done); end
            total++; if (m_words !== CNT_W'(n)) begin bad++; $display("FAIL rnd%0d_words got=%0d exp=%0d", it, m_words, n); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        bit         ok;
        int         base;
        sel = 1'b0;
        do_reset();
        b = '{8'h00, 8'h01, 8'h11, 8'h22};
        send(b, 0, ok);
        do_reset();
        base = q_addr.size();
        b = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send(b, 2, ok);
        wait_end();
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_send got=%b exp=1", ok); end
        total++; if (q_addr.size() - base !== 1) begin bad++; $display("FAIL midrst_nwrites got=%0d exp=1", q_addr.size() - base); end
        if (q_addr.size() > base) begin
            total++; if (q_addr[base] !== 32'h0) begin bad++; $display("FAIL midrst_addr got=%h exp=0", q_addr[base]); end
            total++; if (q_data[base] !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_data got=%h exp=deadbeef", q_data[base]); end
        end
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL midrst_done got=%b exp=1", m_done); end
    endtask

    task automatic test_max4();
        logic [7:0]  b[$];
        logic [31:0] ea[$], ed[$];
        bit          eerr, ok;
        int          base, a0;
        sel = 1'b1;
        do_reset();
        b = '{8'h00, 8'h04};
        for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
        model(b, 4, ea, ed, eerr);
        base = q_addr.size();
        send(b, 3, ok);
        wait_end();
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL max4_send got=%b exp=1", ok); end
        total++; if (q_addr.size() - base !== 4) begin bad++; $display("FAIL max4_nwrites got=%0d exp=4", q_addr.size() - base); end
        for (int i = 0; i < ea.size() && base + i < q_addr.size(); i++) begin
            total++; if (q_addr[base+i] !== ea[i]) begin bad++; $display("FAIL max4_addr%0d got=%h exp=%h", i, q_addr[base+i], ea[i]); end
            total++; if (q_data[base+i] !== ed[i]) begin bad++; $display("FAIL max4_data%0d got=%h exp=%h", i, q_data[base+i], ed[i]); end
        end
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL max4_done got=%b exp=1", m_done); end
        a0 = acc_cnt;
        h_valid = 1'b1;
        h_data  = 8'h77;
        repeat (6) @(posedge clk);
        #1;
        h_valid = 1'b0;
        total++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL max4_refuse got=%0d exp=0", acc_cnt - a0); end
        total++; if (m_words !== 16'd4) begin bad++; $display("FAIL max4_words got=%0d exp=4", m_words); end
        // One word over the depth is rejected.
        do_reset();
        b = '{8'h00, 8'h05};
        send(b, 0, ok);
        idle(1);
        total++; if (m_err !== 1'b1) begin bad++; $display("FAIL max4_over_error got=%b exp=1", m_err); end
        sel = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        sel     = 1'b0;
        h_valid = 1'b0;
        h_data  = 8'h00;
        test_reset();
        test_basic();
        test_bad_header();
        test_timeout();
        test_random_gaps();
        test_reset_mid();
        test_max4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
